// File: rtl/sysid_boot_sequencer_if.sv
// Sysid slave read port: word select out, combinational read data back.
// No latency or backpressure; the slave answers in the same cycle.
interface sysid_boot_sequencer_if;
  logic        address;
  logic [31:0] readdata;

  modport master (output address, input readdata);
  modport slave  (input address, output readdata);
endinterface

// File: rtl/sysid_boot_sequencer.sv
// Post-reset boot controller: verifies sysid words, then releases core resets one by one.
// Core 0 released at edge 4, core k at edge 4+k*STAGGER_CYCLES; no backpressure, retry only honoured in FAIL.
module sysid_boot_sequencer #(
  parameter int          NUM_CORES      = 4,
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1479909137,
  parameter int          STAGGER_CYCLES = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  sysid_boot_sequencer_if.master    sysid,
  input  logic                      retry,
  output logic [NUM_CORES-1:0]      core_reset_n,
  output logic                      boot_done,
  output logic                      boot_fail,
  output logic [1:0]                mismatch_code
);

  localparam int CNT_W = $clog2(STAGGER_CYCLES) + 1;
  localparam int IDX_W = $clog2(NUM_CORES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CORES - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_ID   = 3'd1;
  localparam logic [2:0] RD_TS   = 3'd2;
  localparam logic [2:0] CHECK   = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;
  localparam logic [2:0] FAIL    = 3'd6;

  logic [2:0]           state;
  logic [31:0]          id_q;
  logic [31:0]          ts_q;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic                 addr_q;
  logic                 id_ne;
  logic                 ts_ne;
  logic [NUM_CORES-1:0] release_mask;

  assign sysid.address = addr_q;
  assign id_ne         = (id_q != EXPECTED_ID);
  assign ts_ne         = (ts_q != EXPECTED_TS);
  // OR-ing a shifted one keeps already-released cores out of reset.
  assign release_mask  = NUM_CORES'(1) << idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      id_q          <= '0;
      ts_q          <= '0;
      cnt           <= '0;
      idx           <= '0;
      addr_q        <= 1'b0;
      core_reset_n  <= '0;
      boot_done     <= 1'b0;
      boot_fail     <= 1'b0;
      mismatch_code <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          addr_q <= 1'b0;
          state  <= RD_ID;
        end
        RD_ID: begin
          id_q   <= sysid.readdata;
          addr_q <= 1'b1;
          state  <= RD_TS;
        end
        RD_TS: begin
          ts_q   <= sysid.readdata;
          addr_q <= 1'b0;
          state  <= CHECK;
        end
        CHECK: begin
          if (!id_ne && !ts_ne) begin
            core_reset_n[0] <= 1'b1;
            if (NUM_CORES == 1) begin
              boot_done <= 1'b1;
              state     <= DONE;
            end else begin
              idx   <= IDX_W'(1);
              cnt   <= '0;
              state <= RELEASE;
            end
          end else begin
            mismatch_code <= {ts_ne, id_ne};
            boot_fail     <= 1'b1;
            state         <= FAIL;
          end
        end
        RELEASE: begin
          if (cnt == CNT_LAST) begin
            cnt          <= '0;
            core_reset_n <= core_reset_n | release_mask;
            if (idx == IDX_LAST) begin
              boot_done <= 1'b1;
              state     <= DONE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: state <= DONE;
        FAIL: begin
          if (retry) begin
            boot_fail     <= 1'b0;
            mismatch_code <= 2'b00;
            state         <= RD_ID;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_boot_sequencer.sv
// Directed bench: default 4-core/16-stagger instance plus a 1-core/1-stagger instance.
// Outputs sampled 1 time unit after each rising edge; edge 1 is the first edge after reset release.
module tb_sysid_boot_sequencer;
  localparam logic [31:0] GOOD_ID = 32'd0;
  localparam logic [31:0] GOOD_TS = 32'd1479909137;

  logic clock;
  logic reset_n;
  logic retry0;
  logic retry1;
  logic [31:0] id0, ts0, id1, ts1;

  logic [3:0] core0_rst_n;
  logic       done0, fail0;
  logic [1:0] code0;
  logic [0:0] core1_rst_n;
  logic       done1, fail1;
  logic [1:0] code1;

  int n_chk  = 0;
  int n_fail = 0;

  sysid_boot_sequencer_if sif0 ();
  sysid_boot_sequencer_if sif1 ();
  assign sif0.readdata = sif0.address ? ts0 : id0;
  assign sif1.readdata = sif1.address ? ts1 : id1;

  sysid_boot_sequencer dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .sysid         (sif0),
    .retry         (retry0),
    .core_reset_n  (core0_rst_n),
    .boot_done     (done0),
    .boot_fail     (fail0),
    .mismatch_code (code0)
  );

  sysid_boot_sequencer #(.NUM_CORES(1), .STAGGER_CYCLES(1)) dut1 (
    .clock         (clock),
    .reset_n       (reset_n),
    .sysid         (sif1),
    .retry         (retry1),
    .core_reset_n  (core1_rst_n),
    .boot_done     (done1),
    .boot_fail     (fail1),
    .mismatch_code (code1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Assert reset, check reset values, release on a falling edge so the next rising edge is edge 1.
  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clock);
    check("rst_core0", 32'(core0_rst_n), 32'h0);
    check("rst_done0", 32'(done0), 32'h0);
    check("rst_fail0", 32'(fail0), 32'h0);
    check("rst_code0", 32'(code0), 32'h0);
    check("rst_addr0", 32'(sif0.address), 32'h0);
    check("rst_core1", 32'(core1_rst_n), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  function automatic logic [3:0] exp_cores(input int e);
    int n;
    if (e < 4) return 4'b0000;
    n = (e - 4) / 16 + 1;
    if (n > 4) n = 4;
    return 4'((1 << n) - 1);
  endfunction

  // Good boot for both instances up to last_e; dut1 gets a retry pulse while in DONE.
  task automatic run_good(input int last_e);
    for (int e = 1; e <= last_e; e++) begin
      retry1 = (e == 10);
      tick();
      retry1 = 1'b0;
      check($sformatf("core0_e%0d", e), 32'(core0_rst_n), 32'(exp_cores(e)));
      check($sformatf("done0_e%0d", e), 32'(done0), 32'(e >= 52));
      check($sformatf("fail0_e%0d", e), 32'(fail0), 32'h0);
      check($sformatf("addr0_e%0d", e), 32'(sif0.address), 32'(e == 2));
      check($sformatf("core1_e%0d", e), 32'(core1_rst_n), 32'(e >= 4));
      check($sformatf("done1_e%0d", e), 32'(done1), 32'(e >= 4));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    retry0  = 1'b0;
    retry1  = 1'b0;
    id0 = GOOD_ID; ts0 = GOOD_TS;
    id1 = GOOD_ID; ts1 = GOOD_TS;

    // Good boot, stagger timing, address sequencing.
    do_reset();
    run_good(60);
    retry0 = 1'b1;
    tick();
    retry0 = 1'b0;
    tick();
    check("done_retry_core0", 32'(core0_rst_n), 32'hF);
    check("done_retry_done0", 32'(done0), 32'h1);
    check("done_retry_fail0", 32'(fail0), 32'h0);

    // Reset asserted mid-sequence, then the whole sequence repeats.
    do_reset();
    run_good(30);
    reset_n = 1'b0;
    #1;
    check("midrst_core0", 32'(core0_rst_n), 32'h0);
    check("midrst_done0", 32'(done0), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    run_good(60);

    // ID mismatch only.
    id0 = 32'h0000_0001;
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("idbad_fail_e%0d", e), 32'(fail0), 32'(e >= 4));
      check($sformatf("idbad_code_e%0d", e), 32'(code0), (e >= 4) ? 32'h1 : 32'h0);
      check($sformatf("idbad_core_e%0d", e), 32'(core0_rst_n), 32'h0);
      check($sformatf("idbad_done_e%0d", e), 32'(done0), 32'h0);
    end

    // Both words wrong, then corrected data and a retry pulse.
    id0 = 32'hFFFF_FFFF;
    ts0 = 32'd0;
    do_reset();
    for (int e = 1; e <= 6; e++) tick();
    check("both_fail", 32'(fail0), 32'h1);
    check("both_code", 32'(code0), 32'h3);
    check("both_core", 32'(core0_rst_n), 32'h0);
    id0 = GOOD_ID;
    ts0 = GOOD_TS;
    retry0 = 1'b1;
    tick();
    retry0 = 1'b0;
    check("retry_fail", 32'(fail0), 32'h0);
    check("retry_code", 32'(code0), 32'h0);
    check("retry_core_r0", 32'(core0_rst_n), 32'h0);
    tick();
    check("retry_addr_r1", 32'(sif0.address), 32'h1);
    check("retry_core_r1", 32'(core0_rst_n), 32'h0);
    tick();
    check("retry_core_r2", 32'(core0_rst_n), 32'h0);
    tick();
    check("retry_core_r3", 32'(core0_rst_n), 32'h1);
    check("retry_fail_r3", 32'(fail0), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
